// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised register file with hardwired x0, optional write bypass and busy scoreboard
module reg_file_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 2,
    parameter int WR_BYPASS     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [ADDRESS_WIDTH-1:0]        wa,
    input  logic [DATA_WIDTH-1:0]           wd,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd,
    output logic [NUM_RD-1:0]               rd_busy,
    input  logic                            alloc_en,
    input  logic [ADDRESS_WIDTH-1:0]        alloc_addr,
    output logic [2**ADDRESS_WIDTH-1:0]     busy_vec
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic                  wr_en;
    logic                  alloc_ok;

    // Writeback and allocation are both suppressed while reset is held.
    assign wr_en    = !rst && we && (wa != '0);
    assign alloc_ok = !rst && alloc_en && (alloc_addr != '0);

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_en) begin
            mem_d[wa]  = wd;
            busy_d[wa] = 1'b0;
        end
        // Applied after the writeback clear so a new claimant keeps the bit set.
        if (alloc_ok) begin
            busy_d[alloc_addr] = 1'b1;
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ra_i;
        logic                     byp_i;

        assign ra_i  = ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        // A same-cycle writeback both supplies the data and resolves the hazard.
        assign byp_i = (WR_BYPASS != 0) && wr_en && (wa == ra_i);

        assign rd[i*DATA_WIDTH +: DATA_WIDTH] = (ra_i == '0) ? '0 :
                                                byp_i        ? wd : mem_q[ra_i];
        assign rd_busy[i] = (ra_i != '0) && busy_q[ra_i] && !byp_i;
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb, bypass and non-bypass instances
module tb_reg_file_sb;

    localparam int K_RD_A = 0, K_BUSY_A = 1, K_RD_B = 2, K_BUSY_B = 3;
    localparam int K_BVEC_A = 4, K_BBIT_A = 5, K_BVEC_B = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [19:0]  ra;
    logic         alloc_en;
    logic [4:0]   alloc_addr;
    logic [127:0] rd_a;
    logic [3:0]   rd_busy_a;
    logic [31:0]  busy_vec_a;
    logic [63:0]  rd_b;
    logic [1:0]   rd_busy_b;
    logic [31:0]  busy_vec_b;

    reg_file_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(4), .WR_BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_a), .rd_busy(rd_busy_a), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(busy_vec_a)
    );

    reg_file_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .WR_BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra[9:0]),
        .rd(rd_b), .rd_busy(rd_busy_b), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(busy_vec_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    logic [31:0] mem_m [32];
    logic [31:0] busy_m;
    bit          model_valid = 1'b0;

    function automatic logic [19:0] pk(input logic [4:0] a0, input logic [4:0] a1,
                                       input logic [4:0] a2, input logic [4:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic push(input int kind, input int port, input logic [31:0] exp, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drive(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                         input logic [19:0] rv, input bit al, input logic [4:0] aa);
        logic [4:0]  ri;
        bit          hit;
        logic [31:0] e_rd;
        rst = r; we = w; wa = a; wd = d; ra = rv; alloc_en = al; alloc_addr = aa;
        if (model_valid) begin
            for (int i = 0; i < 4; i++) begin
                ri   = rv[i*5 +: 5];
                hit  = !r && w && (a != 5'd0) && (a == ri);
                e_rd = (ri == 5'd0) ? 32'd0 : hit ? d : mem_m[ri];
                push(K_RD_A, i, e_rd, "model_rd_a");
                push(K_BUSY_A, i, {31'd0, (ri != 5'd0) && busy_m[ri] && !hit}, "model_busy_a");
                if (i < 2) begin
                    push(K_RD_B, i, (ri == 5'd0) ? 32'd0 : mem_m[ri], "model_rd_b");
                    push(K_BUSY_B, i, {31'd0, (ri != 5'd0) && busy_m[ri]}, "model_busy_b");
                end
            end
            push(K_BVEC_A, 0, busy_m, "model_bvec_a");
            push(K_BVEC_B, 0, busy_m, "model_bvec_b");
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) mem_m[k] = 32'd0;
            busy_m      = 32'd0;
            model_valid = 1'b1;
        end else begin
            if (we && wa != 5'd0) begin
                mem_m[wa]  = wd;
                busy_m[wa] = 1'b0;
            end
            if (alloc_en && alloc_addr != 5'd0) busy_m[alloc_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic [19:0] rv);
        drive(0, 0, 5'd0, 32'd0, rv, 0, 5'd0);
    endtask

    function automatic logic [31:0] actual(input int kind, input int port);
        case (kind)
            K_RD_A:   return rd_a[port*32 +: 32];
            K_BUSY_A: return {31'd0, rd_busy_a[port]};
            K_RD_B:   return rd_b[port*32 +: 32];
            K_BUSY_B: return {31'd0, rd_busy_b[port]};
            K_BVEC_A: return busy_vec_a;
            K_BBIT_A: return {31'd0, busy_vec_a[port]};
            default:  return busy_vec_b;
        endcase
    endfunction

    exp_t        mon_e;
    string       mon_nm;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e   = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_act = actual(mon_e.kind, mon_e.port);
            n_chk++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s port=%0d cyc=%0d: got %h, expected %h",
                         mon_nm, mon_e.port, mon_e.cyc, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        logic [4:0]  idx;
        logic [19:0] rv;
        logic [4:0]  sel [4];
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; alloc_en = 1'b0; alloc_addr = '0;
        @(posedge clk); #1;

        drive(1, 0, 5'd0, 32'd0, 20'd0, 0, 5'd0); tick();
        idle(pk(5, 7, 0, 1));
        push(K_BVEC_A, 0, 32'd0, "reset_bvec");
        push(K_RD_A, 0, 32'd0, "reset_rd");
        tick();

        // reset clears stored data and outstanding claims
        drive(0, 1, 5'd5, 32'hDEADBEEF, 20'd0, 0, 5'd0); tick();
        drive(0, 0, 5'd0, 32'd0, 20'd0, 1, 5'd7); tick();
        idle(pk(5, 7, 0, 0));
        push(K_RD_A, 0, 32'hDEADBEEF, "pre_rst_rd5");
        push(K_BUSY_A, 1, 32'd1, "pre_rst_busy7");
        tick();
        drive(1, 1, 5'd5, 32'h12345678, pk(5, 7, 0, 0), 1, 5'd9); tick();
        idle(pk(5, 7, 0, 0));
        push(K_RD_A, 0, 32'd0, "rst_clear_rd5");
        push(K_BVEC_A, 0, 32'd0, "rst_clear_bvec");
        push(K_BUSY_A, 1, 32'd0, "rst_clear_busy7");
        #1;
        n_chk++;
        if (rd_a[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_rst_rd5: got %h", rd_a[31:0]);
        end
        n_chk++;
        if (busy_vec_a !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_rst_bvec_a: got %h", busy_vec_a);
        end
        n_chk++;
        if (rd_busy_a !== 4'd0) begin
            n_fail++;
            $display("FAIL direct_rst_rd_busy_a: got %h", rd_busy_a);
        end
        n_chk++;
        if (busy_vec_b !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_rst_bvec_b: got %h", busy_vec_b);
        end
        tick();

        // x0 is hardwired
        drive(0, 1, 5'd0, 32'hFFFFFFFF, pk(0, 0, 0, 0), 1, 5'd0);
        for (int p = 0; p < 4; p++) push(K_RD_A, p, 32'd0, "x0_same_cycle");
        tick();
        idle(pk(0, 0, 0, 0));
        for (int p = 0; p < 4; p++) push(K_RD_A, p, 32'd0, "x0_after");
        push(K_RD_B, 1, 32'd0, "x0_after_b");
        push(K_BBIT_A, 0, 32'd0, "x0_busy_bit");
        tick();

        // bypass versus no-bypass
        drive(0, 1, 5'd3, 32'h11, 20'd0, 0, 5'd0); tick();
        drive(0, 1, 5'd3, 32'h22, pk(3, 3, 0, 0), 0, 5'd0);
        push(K_RD_A, 0, 32'h22, "bypass_same");
        push(K_RD_B, 0, 32'h11, "nobypass_same");
        tick();
        idle(pk(3, 3, 0, 0));
        push(K_RD_A, 0, 32'h22, "bypass_next");
        push(K_RD_B, 0, 32'h22, "nobypass_next");
        tick();

        // RAW hazard on x10
        drive(0, 0, 5'd0, 32'd0, pk(10, 0, 0, 0), 1, 5'd10); tick();
        idle(pk(10, 0, 0, 0));
        push(K_BUSY_A, 0, 32'd1, "raw_busy_c1");
        push(K_BBIT_A, 10, 32'd1, "raw_bbit_c1");
        tick();
        idle(pk(10, 0, 0, 0)); tick();
        idle(pk(10, 0, 0, 0)); tick();
        drive(0, 1, 5'd10, 32'h55, pk(10, 0, 0, 0), 0, 5'd0);
        push(K_BUSY_A, 0, 32'd0, "raw_busy_wb");
        push(K_RD_A, 0, 32'h55, "raw_rd_wb");
        push(K_BUSY_B, 0, 32'd1, "raw_busy_wb_nobyp");
        tick();
        idle(pk(10, 0, 0, 0));
        push(K_BBIT_A, 10, 32'd0, "raw_bbit_c5");
        tick();

        // simultaneous allocate and writeback
        drive(0, 1, 5'd8, 32'h88, pk(8, 0, 0, 0), 1, 5'd8); tick();
        idle(pk(8, 0, 0, 0));
        push(K_BBIT_A, 8, 32'd1, "same_idx_busy");
        push(K_RD_A, 0, 32'h88, "same_idx_data");
        tick();
        drive(0, 0, 5'd0, 32'd0, 20'd0, 1, 5'd9); tick();
        drive(0, 1, 5'd9, 32'h99, pk(8, 9, 0, 0), 1, 5'd8); tick();
        idle(pk(8, 9, 0, 0));
        push(K_BBIT_A, 8, 32'd1, "diff_idx_busy8");
        push(K_BBIT_A, 9, 32'd0, "diff_idx_busy9");
        tick();

        // sweep all registers over four ports
        for (int i = 1; i < 32; i++) begin
            idx = i[4:0];
            drive(0, 1, idx, i * 32'h01010101, 20'd0, 0, 5'd0); tick();
        end
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 4; k++) begin
                idx    = 5'(((4 * j + k) % 31) + 1);
                sel[k] = idx;
            end
            rv = pk(sel[0], sel[1], sel[2], sel[3]);
            idle(rv);
            for (int k = 0; k < 4; k++) push(K_RD_A, k, {27'd0, sel[k]} * 32'h01010101, "sweep_rd");
            tick();
        end

        // random alloc/writeback stream against the reference model
        for (int n = 0; n < 80; n++) begin
            drive(($urandom_range(0, 24) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  $urandom, 20'($urandom), $urandom_range(0, 1), 5'($urandom_range(0, 31)));
            tick();
        end

        idle(20'd0);
        @(negedge clk);
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        while (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s cyc=%0d: never checked, expected %h", mon_nm, mon_e.cyc, mon_e.exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's single-write, dual-read integer register file.
- Adds configurable read-port count, hardwired-zero register 0, optional write-to-read bypass, synchronous clear and a per-register busy scoreboard.
- Sits between decode/issue and writeback of the pipelined RISC-V core.
- The issue stage allocates a destination register and then uses the per-port busy flags to stall on RAW hazards until writeback.

Parameters:
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_RD, 2, number of read ports (1..4).
- WR_BYPASS, 1, 1 = same-cycle writeback data is visible on read ports; 0 = visible only after the write edge.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  writeback enable.
- wa  input  ADDRESS_WIDTH  writeback register index.
- wd  input  DATA_WIDTH  writeback data.
- ra  input  NUM_RD*ADDRESS_WIDTH  read indices; port i occupies bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- rd  output  NUM_RD*DATA_WIDTH  read data, packed with the same layout as ra.
- rd_busy  output  NUM_RD  per-port flag: the indexed register has an outstanding write.
- alloc_en  input  1  issue stage claims a destination register.
- alloc_addr  input  ADDRESS_WIDTH  index being claimed.
- busy_vec  output  2**ADDRESS_WIDTH  raw scoreboard state, for debug and verification.

Behaviour:
- Reset:
  - On a rising clk with rst=1, all registers become 0 and all busy bits become 0.
  - During a rst cycle, we and alloc_en are ignored.
  - Reset is synchronous only; there is no asynchronous path.
  - Reset asserted while writes are outstanding discards them; a later writeback to a cleared index writes data normally, and its busy clear is a no-op.
- Write:
  - If we=1 and wa!=0, mem[wa] <= wd at the rising edge.
  - Writes to index 0 are dropped; mem[0] is always 0.
- Read:
  - Combinational; zero cycles from ra to rd.
  - ra_i == 0 always returns 0, with rd_busy_i = 0.
  - WR_BYPASS=1: if we=1, wa!=0 and ra_i==wa, then rd_i = wd in the same cycle; otherwise rd_i = mem[ra_i].
  - WR_BYPASS=0: rd_i = mem[ra_i]; the new value appears the cycle after the write edge.
  - All read ports are independent; multiple ports may read the same index.
- Scoreboard, one busy bit per index. Index 0 is never set.
  - alloc_en=1 and alloc_addr!=0: busy[alloc_addr] <= 1.
  - we=1 and wa!=0: busy[wa] <= 0.
  - Allocate and writeback to the same index in the same cycle: allocate wins, busy stays 1 (a new writer is claiming it).
  - Allocate and writeback to different indices in the same cycle: both take effect.
  - Allocating an already-busy index (WAW) is legal; the bit stays 1. The first writeback clears it; the issue stage is responsible for WAW ordering.
- rd_busy_i:
  - Base value: busy[ra_i] && ra_i!=0.
  - WR_BYPASS=1: additionally cleared when we=1 && wa==ra_i in the same cycle, because the bypassed data resolves the hazard.
  - Same-cycle alloc_en does not affect rd_busy (the registered update takes effect next cycle).
- busy_vec reflects the registered state only, with no bypass.
- Width rules:
  - No arithmetic is performed on data.
  - Indices are compared at full ADDRESS_WIDTH.
  - An ra slice width mismatch is an elaboration error.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, allocate x7, then assert rst for one cycle -> next cycle rd(x5)=0, busy_vec=0, rd_busy=0.
- x0 hardwired: we=1, wa=0, wd=0xFFFFFFFF, alloc_addr=0 -> rd(ra=0)=0, busy_vec[0]=0, on every port.
- Bypass: WR_BYPASS=1, x3=0x11, we=1, wa=3, wd=0x22, ra0=3 -> same cycle rd0=0x22; next cycle still 0x22. Rerun with WR_BYPASS=0 -> same cycle rd0=0x11, next cycle 0x22.
- Scoreboard RAW:
  - Allocate x10 at cycle 0 -> cycle 1 rd_busy0=1 with ra0=10.
  - Writeback x10=0x55 at cycle 4 -> with WR_BYPASS=1, rd_busy0=0 and rd0=0x55 in cycle 4; busy_vec[10]=0 in cycle 5.
- Simultaneous events:
  - alloc x8 and writeback x8 in the same cycle -> busy[8]=1 afterward, mem[8]=wd.
  - alloc x8 with writeback x9 (x9 previously busy) -> busy[8]=1, busy[9]=0.
- Multi-port and sweep: NUM_RD=4, write x1..x31 with value = index*0x01010101, then read four distinct indices per cycle across all ports -> every rd_i matches. Random alloc/writeback stream is checked against a reference busy model each cycle.
